// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step runs per
// cycle on operand magnitudes. Signs are fixed up on the edge that ends the
// run, and that same edge loads HI/LO. MTHI/MTLO complete in a single cycle.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int AW = 2 * WIDTH + 1;
  localparam int CW = $clog2(ITER + 1);

  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } stateT;

  // Two's-complement negation at operand width.
  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Two's-complement negation across the full product width.
  function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  stateT             stateR;
  stateT             nextStateS;
  logic [CW-1:0]     cntR;
  logic [AW-1:0]     accR;
  logic [WIDTH-1:0]  operandR;
  logic              isDivR;
  logic              sgnAR;
  logic              sgnBR;
  logic              bZeroR;

  logic              acceptS;
  logic              mtHiS;
  logic              mtLoS;
  logic              finishS;
  logic              sgnAS;
  logic              sgnBS;
  logic [WIDTH-1:0]  magAS;
  logic [WIDTH-1:0]  magBS;
  logic [AW-1:0]     shiftS;
  logic [WIDTH:0]    sumHiS;
  logic [AW-1:0]     stepAccS;
  logic [2*WIDTH-1:0] prodS;
  logic [WIDTH-1:0]  quotS;
  logic [WIDTH-1:0]  remS;
  logic [WIDTH-1:0]  finHiS;
  logic [WIDTH-1:0]  finLoS;

  // Decode requests in IDLE and form operand signs and magnitudes.
  always_comb begin
    acceptS = 1'b0;
    mtHiS   = 1'b0;
    mtLoS   = 1'b0;
    if ((stateR == IDLE) && start) begin
      case (op)
        3'b000, 3'b001, 3'b010, 3'b011: acceptS = 1'b1;
        3'b100:                         mtHiS   = 1'b1;
        3'b101:                         mtLoS   = 1'b1;
        default:                        acceptS = 1'b0;
      endcase
    end else begin
      acceptS = 1'b0;
    end
    sgnAS = op[0] & srcA[WIDTH-1];
    sgnBS = op[0] & srcB[WIDTH-1];
    magAS = sgnAS ? negW(srcA) : srcA;
    magBS = sgnBS ? negW(srcB) : srcB;
  end

  // Next-state logic; FINISH is the edge that ends RUN, so the register
  // returns straight to IDLE and never idles in FINISH.
  always_comb begin
    nextStateS = stateR;
    finishS    = 1'b0;
    case (stateR)
      IDLE: begin
        if (acceptS) begin
          nextStateS = RUN;
        end else begin
          nextStateS = IDLE;
        end
      end
      RUN: begin
        if (cntR == CNT_LAST) begin
          finishS    = 1'b1;
          nextStateS = IDLE;
        end else begin
          nextStateS = RUN;
        end
      end
      FINISH:  nextStateS = IDLE;
      default: nextStateS = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

  // One iteration step of the accumulator: shift-add or restoring subtract.
  always_comb begin
    shiftS   = {accR[AW-2:0], 1'b0};
    sumHiS   = accR[AW-1:WIDTH];
    stepAccS = accR;
    if (isDivR) begin
      if (shiftS[AW-1:WIDTH] >= {1'b0, operandR}) begin
        stepAccS = {shiftS[AW-1:WIDTH] - {1'b0, operandR}, shiftS[WIDTH-1:1], 1'b1};
      end else begin
        stepAccS = shiftS;
      end
    end else begin
      if (accR[0]) begin
        sumHiS = accR[AW-1:WIDTH] + {1'b0, operandR};
      end else begin
        sumHiS = accR[AW-1:WIDTH];
      end
      stepAccS = {1'b0, sumHiS, accR[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final step into HI/LO values. A zero divisor leaves
  // the dividend as remainder, which the remainder fix-up turns back into srcA.
  always_comb begin
    prodS = stepAccS[2*WIDTH-1:0];
    quotS = stepAccS[WIDTH-1:0];
    remS  = stepAccS[2*WIDTH-1:WIDTH];
    if (isDivR) begin
      finHiS = sgnAR ? negW(remS) : remS;
      if (bZeroR) begin
        finLoS = {WIDTH{1'b1}};
      end else begin
        finLoS = (sgnAR ^ sgnBR) ? negW(quotS) : quotS;
      end
    end else begin
      {finHiS, finLoS} = (sgnAR ^ sgnBR) ? neg2W(prodS) : prodS;
    end
  end

  // Operand latch, iteration counter, accumulator and HI/LO/status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntR     <= {CW{1'b0}};
      accR     <= {AW{1'b0}};
      operandR <= {WIDTH{1'b0}};
      isDivR   <= 1'b0;
      sgnAR    <= 1'b0;
      sgnBR    <= 1'b0;
      bZeroR   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
    end else begin
      done <= finishS;
      if (acceptS) begin
        cntR     <= {CW{1'b0}};
        isDivR   <= op[1];
        sgnAR    <= sgnAS;
        sgnBR    <= sgnBS;
        bZeroR   <= (srcB == {WIDTH{1'b0}});
        operandR <= op[1] ? magBS : magAS;
        accR     <= {{(WIDTH+1){1'b0}}, (op[1] ? magAS : magBS)};
        busy     <= 1'b1;
      end else if (finishS) begin
        cntR <= {CW{1'b0}};
        accR <= stepAccS;
        busy <= 1'b0;
        hi   <= finHiS;
        lo   <= finLoS;
      end else if (stateR == RUN) begin
        cntR <= cntR + CNT_ONE;
        accR <= stepAccS;
      end else begin
        if (mtHiS) begin
          hi <= srcA;
        end else if (mtLoS) begin
          lo <= srcA;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed and randomized checks of mdu_hilo against a
// 64-bit arithmetic reference model.
module tb_mdu_hilo;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] srcA  = 32'h0;
  logic [31:0] srcB  = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          nVec  = 0;
  int          nMis  = 0;
  logic [31:0] expHi = 32'h0;
  logic [31:0] expLo = 32'h0;

  mdu_hilo #(.WIDTH(32), .ITER(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .srcA (srcA),
    .srcB (srcB),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // Reference: returns {hi, lo} for a mul/div op using plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q;
    int     r;
    case (o)
      3'b000: return {32'h0, a} * {32'h0, b};
      3'b001: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      3'b010: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'b011: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nVec++;
    assert (got === want)
    else begin
      nMis++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Issue a mul/div at the current negedge and wait for its done pulse.
  // With poke set, an MTLO request is held on start throughout the busy window.
  task automatic issueAndWait(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                              input bit poke, input string tag);
    logic [63:0] r;
    int          cyc;
    r     = model(o, a, b);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    @(negedge clk);
    start = poke;
    op    = 3'b101;
    srcA  = $urandom;
    srcB  = $urandom;
    cyc   = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
      srcA = $urandom;
    end
    start = 1'b0;
    expHi = r[63:32];
    expLo = r[31:0];
    check({tag, " busy_cycles"}, 32'(cyc), 32'd32);
    check({tag, " done"}, {31'h0, done}, 32'd1);
    check({tag, " hi"}, hi, expHi);
    check({tag, " lo"}, lo, expLo);
  endtask

  initial begin
    int dn;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;

    // Reset, then idle for three cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'h0, busy}, 32'd0);
    check("reset done", {31'h0, done}, 32'd0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);

    // Directed mul/div corner cases.
    issueAndWait(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    check("multu_max hi_const", hi, 32'hFFFF_FFFE);
    check("multu_max lo_const", lo, 32'h0000_0001);
    @(negedge clk);
    check("done_drop", {31'h0, done}, 32'd0);
    check("busy_after", {31'h0, busy}, 32'd0);
    issueAndWait(3'b001, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg3x7");
    check("mult_neg3x7 lo_const", lo, 32'hFFFF_FFEB);
    issueAndWait(3'b010, 32'd100, 32'd7, 1'b0, "divu_100_7");
    issueAndWait(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    check("div_m7_2 lo_const", lo, 32'hFFFF_FFFD);
    issueAndWait(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    issueAndWait(3'b010, 32'd5, 32'd0, 1'b0, "divu_by0");
    check("divu_by0 hi_const", hi, 32'd5);
    issueAndWait(3'b011, 32'hFFFF_FFFB, 32'd0, 1'b0, "div_neg_by0");
    @(negedge clk);

    // MTHI in IDLE: single cycle, lo untouched, no busy/done.
    start = 1'b1; op = 3'b100; srcA = 32'hBBBB_BBBB;
    @(negedge clk);
    start = 1'b0;
    expHi = 32'hBBBB_BBBB;
    check("mthi hi", hi, expHi);
    check("mthi lo", lo, expLo);
    check("mthi busy", {31'h0, busy}, 32'd0);
    check("mthi done", {31'h0, done}, 32'd0);

    // No-op encoding leaves everything alone.
    start = 1'b1; op = 3'b110; srcA = 32'h1357_9BDF;
    @(negedge clk);
    start = 1'b0;
    check("noop hi", hi, expHi);
    check("noop lo", lo, expLo);
    check("noop busy", {31'h0, busy}, 32'd0);

    // MTLO while a MULT is busy is ignored.
    issueAndWait(3'b001, $urandom, $urandom, 1'b1, "mult_mtlo_ignored");

    // Back-to-back: the second op is issued in the done cycle.
    issueAndWait(3'b010, $urandom, $urandom_range(1, 1000), 1'b0, "b2b_first");
    issueAndWait(3'b011, $urandom, $urandom, 1'b0, "b2b_second");
    @(negedge clk);

    // Randomized mul/div.
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 3));
      a = pick();
      b = pick();
      issueAndWait(o, a, b, 1'b0, "random");
    end
    @(negedge clk);

    // Async reset in the middle of a run.
    start = 1'b1; op = 3'b100; srcA = 32'hA5A5_A5A5;
    @(negedge clk);
    start = 1'b1; op = 3'b101; srcA = 32'h5A5A_5A5A;
    @(negedge clk);
    start = 1'b1; op = 3'b001; srcA = 32'd12345; srcB = 32'hFFFF_FFF7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_reset busy", {31'h0, busy}, 32'd1);
    check("pre_reset hi", hi, 32'hA5A5_A5A5);
    #2 rst = 1'b1;
    #1;
    check("async busy", {31'h0, busy}, 32'd0);
    check("async hi", hi, 32'h0);
    check("async lo", lo, 32'h0);
    check("async done", {31'h0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dn  = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    check("no_done_after_reset", 32'(dn), 32'd0);
    issueAndWait(3'b000, 32'd2, 32'd3, 1'b0, "multu_after_reset");
    check("multu_after_reset lo_const", lo, 32'd6);
    check("multu_after_reset hi_const", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
